// File: rtl/axi_dma_read.sv
// AXI4 read master: splits a transfer into INCR bursts (<= BURST_LEN, never crossing 4 KB) and streams R beats into the DMA FIFO.
// Latency: start -> arvalid 1 cycle; R beat -> FIFO write 0 cycles; last beat -> next arvalid or done 1 cycle.
// Backpressure: rready drops whenever fifo_full is high; arvalid/araddr/arlen hold until arready.
module axi_dma_read #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [LEN_WIDTH-1:0]  xfer_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  fifo_wr_en,
    input  logic                  fifo_full
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    // Wide enough for both the beat count and the 4 KB page distance (up to 4096 beats).
    localparam int CW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  error_q, error_d;

    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [ADDR_WIDTH-1:0] next_burst_addr;
    logic [LEN_WIDTH-1:0]  calc_rem;
    logic [CW-1:0]         page_beats;
    logic [CW-1:0]         calc_beats;
    logic                  beat_acc;
    logic                  last_beat;
    logic                  resp_err;
    logic                  burst_issue;

    assign beat_acc        = rvalid & rready;
    assign last_beat       = (beat_cnt_q == arlen_q);
    assign resp_err        = (rresp == 2'b10) || (rresp == 2'b11);
    // Start of the burst following the one in flight; wraps at 2^ADDR_WIDTH.
    assign next_burst_addr = araddr_q + ((ADDR_WIDTH'(arlen_q) + ADDR_WIDTH'(1)) << SIZE);

    // Size the next burst: min(remaining, BURST_LEN, beats left in this 4 KB page)
    always_comb begin
        calc_addr  = (state_q == S_IDLE) ? src_addr   : next_burst_addr;
        calc_rem   = (state_q == S_IDLE) ? xfer_beats : rem_q;
        page_beats = CW'(13'h1000 - {1'b0, calc_addr[11:0]}) >> SIZE;
        calc_beats = CW'(calc_rem);
        if (calc_beats > CW'(BURST_LEN)) begin
            calc_beats = CW'(BURST_LEN);
        end
        if (calc_beats > page_beats) begin
            calc_beats = page_beats;
        end
    end

    // Next-state, burst bookkeeping and error tracking
    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        rem_d       = rem_q;
        beat_cnt_d  = beat_cnt_q;
        error_d     = error_q;
        burst_issue = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (xfer_beats == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_AR;
                        burst_issue = 1'b1;
                    end
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // A bad response or an rlast that disagrees with the counter flags the transfer.
                    if (resp_err || (rlast != last_beat)) begin
                        error_d = 1'b1;
                    end
                    // The counter, not rlast, decides where the burst ends.
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        if (error_d || (rem_q == '0)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_AR;
                            burst_issue = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Remaining count is debited as soon as a burst is committed to the AR channel.
        if (burst_issue) begin
            araddr_d = calc_addr;
            arlen_d  = 8'(calc_beats - CW'(1));
            rem_d    = calc_rem - LEN_WIDTH'(calc_beats);
        end
    end

    // State registers; reset drops any burst in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            araddr_q   <= '0;
            arlen_q    <= '0;
            rem_q      <= '0;
            beat_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            rem_q      <= rem_d;
            beat_cnt_q <= beat_cnt_d;
            error_q    <= error_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = error_q;
    assign arvalid    = (state_q == S_AR);
    assign araddr     = araddr_q;
    assign arlen      = arlen_q;
    assign arsize     = 3'(SIZE);
    assign arburst    = 2'b01;
    assign rready     = (state_q == S_DATA) && !fifo_full;
    assign fifo_wr_en = rvalid & rready;
    assign fifo_wdata = rdata;

endmodule

// File: tb/tb_axi_dma_read.sv
// Bench for axi_dma_read: AXI slave + FIFO model with random stalls, scoreboarded against a burst-splitting reference.
// Timing: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: fifo_full can be held low, toggled every cycle, or randomised.
module tb_axi_dma_read;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr;
    logic [15:0] xfer_beats;
    logic        busy, done, error;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [31:0] fifo_wdata;
    logic        fifo_wr_en, fifo_full;

    axi_dma_read dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .xfer_beats(xfer_beats),
        .busy(busy), .done(done), .error(error),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .fifo_wdata(fifo_wdata), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed traffic
    logic [31:0] ar_addr_q[$];
    int          ar_len_q[$];
    logic [31:0] wr_q[$];
    int          done_cnt, viol, done_cyc, last_wr_cyc;
    logic        post_busy;

    // Expected traffic
    logic [31:0] exp_ar_addr[$];
    int          exp_ar_len[$];
    logic [31:0] exp_wr[$];

    // Slave configuration
    int err_beat      = -1;
    int bad_last_beat = -1;
    bit rnd_mode      = 0;
    int fifo_mode     = 0;

    // Slave state
    bit          have_burst, took, prev_ar_stall, exp_ar_or_done, prev_done;
    logic [31:0] b_addr, prev_araddr;
    logic [7:0]  prev_arlen;
    int          b_len, b_idx, g_beat;

    logic pre_busy, arvalid_n1, busy_n1, done_n1;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3C3_0F0F;
    endfunction

    // Reference: split into bursts by plain arithmetic, stop after the burst holding beat errb
    function automatic void build_model(input logic [31:0] a0, input int n0, input int errb);
        logic [31:0] a;
        int n, b, page, g;
        bit stop;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_wr.delete();
        a = a0; n = n0; g = 0; stop = 0;
        while (n > 0 && !stop) begin
            page = (4096 - int'(a[11:0])) / 4;
            b = n;
            if (b > 8) b = 8;
            if (b > page) b = page;
            exp_ar_addr.push_back(a);
            exp_ar_len.push_back(b - 1);
            for (int i = 0; i < b; i++) begin
                exp_wr.push_back(dat(a + 32'(4 * i)));
                if (g == errb) stop = 1;
                g++;
            end
            a = a + 32'(4 * b);
            n = n - b;
        end
    endfunction

    // AXI slave, FIFO-full driver and protocol monitor
    initial begin
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; fifo_full = 0;
        forever begin
            @(negedge clk);
            took = 0;
            if (!reset_n) begin
                have_burst = 0; prev_ar_stall = 0; exp_ar_or_done = 0; prev_done = 0;
            end else begin
                if (prev_done) post_busy = busy;
                prev_done = done;
                if (exp_ar_or_done && !arvalid && !done) viol++;
                exp_ar_or_done = 0;
                if (prev_ar_stall && (!arvalid || araddr !== prev_araddr || arlen !== prev_arlen)) viol++;
                prev_ar_stall = arvalid && !arready;
                prev_araddr = araddr; prev_arlen = arlen;
                if (fifo_full && rready) viol++;
                if (fifo_wr_en !== (rvalid && rready) || fifo_wdata !== rdata) viol++;
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (arvalid && arready) begin
                    if (have_burst) viol++;
                    if (int'(araddr[11:0]) + (int'(arlen) + 1) * 4 > 4096) viol++;
                    ar_addr_q.push_back(araddr);
                    ar_len_q.push_back(int'(arlen));
                    have_burst = 1; b_addr = araddr; b_len = int'(arlen) + 1; b_idx = 0;
                end
                if (fifo_wr_en) begin
                    if (!have_burst) viol++;
                    took = 1;
                    wr_q.push_back(fifo_wdata);
                    last_wr_cyc = cyc;
                    b_idx++; g_beat++;
                    if (b_idx >= b_len) begin have_burst = 0; exp_ar_or_done = 1; end
                end
            end
            @(posedge clk); #1;
            if (!reset_n) begin
                arready = 0; rvalid = 0; rlast = 0; rresp = 0;
            end else begin
                arready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (have_burst) begin
                    if (!(rvalid && !took)) rvalid = rnd_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
                    rdata = dat(b_addr + 32'(4 * b_idx));
                    rresp = (g_beat == err_beat) ? 2'b10 : 2'b00;
                    rlast = (b_idx == b_len - 1) ^ (g_beat == bad_last_beat);
                end else begin
                    rvalid = 0; rlast = 0; rresp = 0;
                end
                case (fifo_mode)
                    1: fifo_full = ~fifo_full;
                    2: fifo_full = ($urandom_range(0, 3) == 0);
                    default: fifo_full = 0;
                endcase
            end
        end
    end

    task automatic run_xfer(input logic [31:0] a, input int n, input bit spur, output bit to);
        ar_addr_q.delete(); ar_len_q.delete(); wr_q.delete();
        done_cnt = 0; g_beat = 0; viol = 0; done_cyc = -1; last_wr_cyc = -1; post_busy = 1'b1;
        @(posedge clk); #1;
        src_addr = a; xfer_beats = 16'(n); start = 1; pre_busy = busy;
        @(posedge clk); #1;
        start = 0; arvalid_n1 = arvalid; busy_n1 = busy; done_n1 = done;
        if (spur && n > 0) begin
            @(posedge clk); #1;
            src_addr = 32'hDEAD_0000; xfer_beats = 16'd3; start = 1;
            @(posedge clk); #1;
            start = 0;
        end
        to = 1;
        for (int i = 0; i < 4000; i++) begin
            if (done_cnt > 0) begin to = 0; break; end
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 0; start = 0; src_addr = 0; xfer_beats = 0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({arvalid, rready, busy, done, error, fifo_wr_en} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 000000", {arvalid, rready, busy, done, error, fifo_wr_en});
        end
        n_tests++;
        if (araddr !== 32'h0 || arlen !== 8'h0) begin
            n_fail++; $display("FAIL reset_ar got araddr=%h arlen=%0d want 0/0", araddr, arlen);
        end
        n_tests++;
        if (arsize !== 3'd2 || arburst !== 2'b01) begin
            n_fail++; $display("FAIL const_ar got arsize=%0d arburst=%b want 2/01", arsize, arburst);
        end
        reset_n = 1;
    endtask

    task automatic test_basic;
        bit to;
        logic [31:0] ea [3];
        int el [3];
        ea[0] = 32'h1000; ea[1] = 32'h1020; ea[2] = 32'h1040;
        el[0] = 7; el[1] = 7; el[2] = 3;
        rnd_mode = 0; fifo_mode = 0; err_beat = -1; bad_last_beat = -1;
        build_model(32'h1000, 20, -1);
        run_xfer(32'h1000, 20, 0, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout no done within bound"); end
        n_tests++;
        if (pre_busy !== 1'b0 || arvalid_n1 !== 1'b1 || busy_n1 !== 1'b1) begin
            n_fail++; $display("FAIL basic_start_timing got busyN=%b arvalidN1=%b busyN1=%b want 0 1 1", pre_busy, arvalid_n1, busy_n1);
        end
        n_tests++;
        if (ar_addr_q.size() != 3) begin n_fail++; $display("FAIL basic_ar_count got %0d want 3", ar_addr_q.size()); end
        for (int i = 0; i < 3 && i < ar_addr_q.size(); i++) begin
            n_tests++;
            if (ar_addr_q[i] !== ea[i] || ar_len_q[i] != el[i]) begin
                n_fail++; $display("FAIL basic_ar%0d got %h/%0d want %h/%0d", i, ar_addr_q[i], ar_len_q[i], ea[i], el[i]);
            end
        end
        n_tests++;
        if (wr_q.size() != 20) begin n_fail++; $display("FAIL basic_wr_count got %0d want 20", wr_q.size()); end
        for (int i = 0; i < 20 && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i] !== exp_wr[i]) begin n_fail++; $display("FAIL basic_data%0d got %h want %h", i, wr_q[i], exp_wr[i]); end
        end
        n_tests++;
        if (done_cnt != 1 || error !== 1'b0 || viol != 0) begin
            n_fail++; $display("FAIL basic_status got done=%0d error=%b viol=%0d want 1 0 0", done_cnt, error, viol);
        end
        n_tests++;
        if (done_cyc != last_wr_cyc + 1 || post_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_end_timing got done_cyc=%0d last_wr=%0d busy_after=%b want last+1, 0", done_cyc, last_wr_cyc, post_busy);
        end
    endtask

    task automatic test_boundary;
        bit to;
        build_model(32'h0FF8, 8, -1);
        run_xfer(32'h0FF8, 8, 0, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL bound_timeout no done within bound"); end
        n_tests++;
        if (ar_addr_q.size() != 2) begin
            n_fail++; $display("FAIL bound_ar_count got %0d want 2", ar_addr_q.size());
        end else if (ar_addr_q[0] !== 32'h0FF8 || ar_len_q[0] != 1 || ar_addr_q[1] !== 32'h1000 || ar_len_q[1] != 5) begin
            n_fail++; $display("FAIL bound_ar got %h/%0d %h/%0d want 00000ff8/1 00001000/5", ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]);
        end
        n_tests++;
        if (wr_q.size() != 8 || viol != 0) begin n_fail++; $display("FAIL bound_wr got %0d writes viol=%0d want 8 0", wr_q.size(), viol); end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i] !== exp_wr[i]) begin n_fail++; $display("FAIL bound_data%0d got %h want %h", i, wr_q[i], exp_wr[i]); end
        end
    endtask

    task automatic test_fifo_toggle;
        bit to;
        fifo_mode = 1;
        build_model(32'h2000, 8, -1);
        run_xfer(32'h2000, 8, 0, to);
        fifo_mode = 0;
        n_tests++; if (to) begin n_fail++; $display("FAIL fifo_timeout no done within bound"); end
        n_tests++;
        if (viol != 0) begin n_fail++; $display("FAIL fifo_protocol got %0d violations (rready while full or lost beat) want 0", viol); end
        n_tests++;
        if (wr_q.size() != 8 || ar_addr_q.size() != 1) begin
            n_fail++; $display("FAIL fifo_counts got wr=%0d ar=%0d want 8 1", wr_q.size(), ar_addr_q.size());
        end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i] !== exp_wr[i]) begin n_fail++; $display("FAIL fifo_data%0d got %h want %h", i, wr_q[i], exp_wr[i]); end
        end
    endtask

    task automatic test_slverr;
        bit to;
        err_beat = 2;
        build_model(32'h4000, 16, 2);
        run_xfer(32'h4000, 16, 0, to);
        err_beat = -1;
        n_tests++; if (to) begin n_fail++; $display("FAIL slverr_timeout no done within bound"); end
        n_tests++;
        if (ar_addr_q.size() != 1 || wr_q.size() != 8) begin
            n_fail++; $display("FAIL slverr_counts got ar=%0d wr=%0d want 1 8", ar_addr_q.size(), wr_q.size());
        end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i] !== exp_wr[i]) begin n_fail++; $display("FAIL slverr_data%0d got %h want %h", i, wr_q[i], exp_wr[i]); end
        end
        n_tests++;
        if (error !== 1'b1 || done_cnt != 1 || viol != 0) begin
            n_fail++; $display("FAIL slverr_status got error=%b done=%0d viol=%0d want 1 1 0", error, done_cnt, viol);
        end
    endtask

    task automatic test_rlast_early;
        bit to;
        bad_last_beat = 4;
        run_xfer(32'h5000, 16, 0, to);
        bad_last_beat = -1;
        n_tests++;
        if (to || ar_addr_q.size() != 1 || wr_q.size() != 8 || error !== 1'b1) begin
            n_fail++; $display("FAIL rlast_early got timeout=%b ar=%0d wr=%0d error=%b want 0 1 8 1", to, ar_addr_q.size(), wr_q.size(), error);
        end
    endtask

    task automatic test_zero_len;
        bit to;
        run_xfer(32'h6000, 0, 0, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL zero_timeout no done within bound"); end
        n_tests++;
        if (arvalid_n1 !== 1'b0 || done_n1 !== 1'b1 || busy_n1 !== 1'b1) begin
            n_fail++; $display("FAIL zero_timing got arvalid=%b done=%b busy=%b in N+1 want 0 1 1", arvalid_n1, done_n1, busy_n1);
        end
        n_tests++;
        if (ar_addr_q.size() != 0 || wr_q.size() != 0 || done_cnt != 1 || error !== 1'b0 || post_busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_status got ar=%0d wr=%0d done=%0d error=%b busy_after=%b want 0 0 1 0 0",
                               ar_addr_q.size(), wr_q.size(), done_cnt, error, post_busy);
        end
        build_model(32'h6000, 4, -1);
        run_xfer(32'h6000, 4, 0, to);
        n_tests++;
        if (to || ar_addr_q.size() != 1 || wr_q.size() != 4 || error !== 1'b0) begin
            n_fail++; $display("FAIL zero_then4 got timeout=%b ar=%0d wr=%0d error=%b want 0 1 4 0", to, ar_addr_q.size(), wr_q.size(), error);
        end else if (ar_addr_q[0] !== 32'h6000 || ar_len_q[0] != 3 || wr_q[3] !== exp_wr[3]) begin
            n_fail++; $display("FAIL zero_then4_ar got %h/%0d last=%h want 00006000/3 last=%h", ar_addr_q[0], ar_len_q[0], wr_q[3], exp_wr[3]);
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        int waited;
        ar_addr_q.delete(); ar_len_q.delete(); wr_q.delete(); g_beat = 0;
        @(posedge clk); #1;
        src_addr = 32'h3000; xfer_beats = 16'd16; start = 1;
        @(posedge clk); #1;
        start = 0;
        waited = 0;
        while (wr_q.size() < 4 && waited < 200) begin @(negedge clk); #1; waited++; end
        n_tests++;
        if (waited >= 200) begin n_fail++; $display("FAIL rstmid_timeout got %0d beats want 4", wr_q.size()); end
        reset_n = 0;
        #1;
        n_tests++;
        if ({arvalid, rready, busy, done, error, fifo_wr_en} !== 6'b0 || araddr !== 32'h0 || arlen !== 8'h0) begin
            n_fail++; $display("FAIL rstmid_outputs got ctrl=%b araddr=%h arlen=%0d want 000000/0/0",
                               {arvalid, rready, busy, done, error, fifo_wr_en}, araddr, arlen);
        end
        repeat (2) @(negedge clk);
        #2 reset_n = 1;
        build_model(32'h7000, 12, -1);
        run_xfer(32'h7000, 12, 0, to);
        n_tests++;
        if (to || ar_addr_q.size() != exp_ar_addr.size() || wr_q.size() != 12 || done_cnt != 1 || viol != 0) begin
            n_fail++; $display("FAIL rstmid_after got timeout=%b ar=%0d wr=%0d done=%0d viol=%0d want 0 %0d 12 1 0",
                               to, ar_addr_q.size(), wr_q.size(), done_cnt, viol, exp_ar_addr.size());
        end
        for (int i = 0; i < 12 && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i] !== exp_wr[i]) begin n_fail++; $display("FAIL rstmid_data%0d got %h want %h", i, wr_q[i], exp_wr[i]); end
        end
    endtask

    task automatic test_random;
        bit to, spur, exp_err;
        logic [31:0] a, hi;
        int n, errb;
        rnd_mode = 1; fifo_mode = 2;
        for (int t = 0; t < 30; t++) begin
            hi = $urandom;
            if (t == 0) a = 32'hFFFF_FFF0;
            else if ($urandom_range(0, 1) == 1) a = {hi[31:12], 12'(4096 - 4 * $urandom_range(1, 24))};
            else a = {hi[31:12], 12'(4 * $urandom_range(0, 1023))};
            n = (t == 0) ? 8 : $urandom_range(0, 40);
            errb = -1; err_beat = -1; bad_last_beat = -1;
            if (t > 0 && $urandom_range(0, 4) == 0) begin
                errb = $urandom_range(0, 40);
                if ($urandom_range(0, 1) == 1) err_beat = errb; else bad_last_beat = errb;
            end
            exp_err = (errb >= 0) && (errb < n);
            spur = ($urandom_range(0, 2) == 0);
            build_model(a, n, errb);
            run_xfer(a, n, spur, to);
            n_tests++;
            if (to || done_cnt != 1 || viol != 0 || error !== exp_err) begin
                n_fail++; $display("FAIL rand%0d_status got timeout=%b done=%0d viol=%0d error=%b want 0 1 0 %b", t, to, done_cnt, viol, error, exp_err);
            end
            n_tests++;
            if (ar_addr_q.size() != exp_ar_addr.size() || wr_q.size() != exp_wr.size()) begin
                n_fail++; $display("FAIL rand%0d_counts got ar=%0d wr=%0d want %0d %0d", t, ar_addr_q.size(), wr_q.size(), exp_ar_addr.size(), exp_wr.size());
            end
            for (int i = 0; i < exp_ar_addr.size() && i < ar_addr_q.size(); i++) begin
                n_tests++;
                if (ar_addr_q[i] !== exp_ar_addr[i] || ar_len_q[i] != exp_ar_len[i]) begin
                    n_fail++; $display("FAIL rand%0d_ar%0d got %h/%0d want %h/%0d", t, i, ar_addr_q[i], ar_len_q[i], exp_ar_addr[i], exp_ar_len[i]);
                end
            end
            for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
                n_tests++;
                if (wr_q[i] !== exp_wr[i]) begin n_fail++; $display("FAIL rand%0d_data%0d got %h want %h", t, i, wr_q[i], exp_wr[i]); end
            end
            n_tests++;
            if ((n > 0 && done_cyc != last_wr_cyc + 1) || (n == 0 && done_n1 !== 1'b1) || post_busy !== 1'b0) begin
                n_fail++; $display("FAIL rand%0d_timing got done_cyc=%0d last_wr=%0d doneN1=%b busy_after=%b", t, done_cyc, last_wr_cyc, done_n1, post_busy);
            end
        end
        rnd_mode = 0; fifo_mode = 0; err_beat = -1; bad_last_beat = -1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_fifo_toggle();
        test_slverr();
        test_zero_len();
        test_rlast_early();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
